serial_subtractor: RTL and testbench

//   Bit-serial subtractor: inverse datapath of the combinational adder tile.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: accepts a, b over a valid/ready handshake,
// produces a - b LSB-first over WIDTH clocks and holds the result until taken.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  operand handshake (ready only while idle)
//   a, b               minuend and subtrahend
//   out_valid/out_ready result handshake (valid only while done)
//   diff, borrow       (a - b) mod 2^WIDTH and unsigned underflow flag
//   busy               operation in progress or result pending
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             bit_d;
    logic             br_nxt;

    // One full-subtractor slice on the current LSBs.
    assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The minuend register doubles as the result shift register:
                // each consumed LSB frees its MSB for the new difference bit.
                a_d   = {bit_d, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d   = {bit_d, a_q[WIDTH-1:1]};
                    borrow_d = br_nxt;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors,
// backpressure, mid-run reset and randomized operands with stalls.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        int           acc;
    } exp_t;

    exp_t expq[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total = 0;
    int   n_in = 0;
    int   n_out = 0;
    bit   prev_v = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard when a result is first presented.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && !prev_v) begin
            if (expq.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got diff %0d with no operation pending",
                         diff);
            end else begin
                e = expq.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow", 32'(borrow), 32'(e.br));
                chk("latency", 32'(cyc - e.acc), 32'(W + 1));
            end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) n_out++;
        prev_v = (out_valid === 1'b1);
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ed, input logic eb);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        expq.push_back('{d: ed, br: eb, acc: cyc});
        n_in++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) begin
            total++;
            $display("FAIL out_valid_timeout: got %b expected 1", out_valid);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || in_ready !== 1'b1) && n < 500) begin
            tick();
            n++;
        end
        if (expq.size() != 0 || in_ready !== 1'b1) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;

        repeat (2) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);

        op(8'd200, 8'd55, 8'd145, 1'b0);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_in_ready", 32'(in_ready), 32'd0);
        drain();
        chk("retain_diff", 32'(diff), 32'd145);

        op(8'd0, 8'd0, 8'd0, 1'b0);
        op(8'd255, 8'd255, 8'd0, 1'b0);
        op(8'd0, 8'd1, 8'd255, 1'b1);
        drain();

        // Backpressure in DONE.
        out_ready = 1'b0;
        op(8'd5, 8'd9, 8'd252, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_diff", 32'(diff), 32'd252);
            chk("hold_borrow", 32'(borrow), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_retain", 32'(diff), 32'd252);

        // in_valid during RUN is ignored.
        op(8'd100, 8'd30, 8'd70, 1'b0);
        tick();
        in_valid = 1'b1;
        a = 8'd1;
        b = 8'd1;
        tick();
        in_valid = 1'b0;
        drain();

        // Reset mid-RUN discards the operation.
        op(8'd50, 8'd20, 8'd30, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expq.delete();
        n_in--;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        repeat (W + 3) tick();
        op(8'd10, 8'd3, 8'd7, 1'b0);
        drain();

        // Randomized operands with input gaps and output stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            op(ra, rb, W'(ra - rb), (ra < rb));
        end
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        drain();
        tick();
        chk("handshakes", 32'(n_out), 32'(n_in));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
